// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types for the byte-serial memory arbiter.
// Holds the controller state encoding, the requester grant ids, the
// transfer size codes and the size-to-last-byte-index helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_XFER   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_AXI = 1'b1
   } gnt_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Index of the final byte of a transfer (N-1); both 1x codes mean a word.
   function automatic logic [1:0] size_last(input logic [1:0] size);
      logic [1:0] last;
      case (size)
         SIZE_BYTE: last = 2'd0;
         SIZE_HALF: last = 2'd1;
         default:   last = 2'd3;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the CPU, AXI-loader and byte-memory signals.
// slave  : arbiter view (requests/read byte in, completions/memory strobes out)
// master : environment view (drives requests and the memory read byte)
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;
   logic              axi_req;
   logic [ADDR_W-1:0] axi_addr;
   logic [DATA_W-1:0] axi_wdata;
   logic              axi_done;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      input  axi_req, axi_addr, axi_wdata, mem_rdata,
      output cpu_rdata, cpu_done, axi_done,
      output mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
      output axi_req, axi_addr, axi_wdata, mem_rdata,
      input  cpu_rdata, cpu_done, axi_done,
      input  mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin grant decision (purely combinational).
// req[0] = CPU, req[1] = AXI; last_gnt = requester granted most recently;
// grant = one-hot winner, all-zero when nobody requests.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  gnt_t       last_gnt,
   output logic [1:0] grant
);

   // Lone request wins outright; on a tie the one not served last wins.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_gnt == GNT_CPU) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one byte-wide memory port between a CPU (byte/half/
// word loads and stores) and an AXI loader (word writes). A granted request
// is serialised into N little-endian byte accesses, then a one-cycle done.
// Ports: clk, rst_n (synchronous, active-low), bus (mem_arbiter_if.slave).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   state_t            state_r, state_s;
   gnt_t              gnt_r, gnt_s;
   gnt_t              last_gnt_r, last_gnt_s;
   logic              we_r, we_s;
   logic [1:0]        last_r, last_s;
   logic [1:0]        n_r, n_s;
   logic [1:0]        lane_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic [DATA_W-1:0] wdata_r, wdata_s;
   logic [DATA_W-1:0] rd_buf_r, rd_buf_s;
   logic [DATA_W-1:0] cpu_rdata_r, cpu_rdata_s;
   logic              cpu_done_r, cpu_done_s;
   logic              axi_done_r, axi_done_s;
   logic              mem_en_r, mem_en_s;
   logic              mem_we_r, mem_we_s;
   logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
   logic [7:0]        mem_wdata_r, mem_wdata_s;
   logic              busy_r, busy_s;
   logic [1:0]        grant_s;

   rr_arb2 u_rr_arb2 (
      .req      ({bus.axi_req, bus.cpu_req}),
      .last_gnt (last_gnt_r),
      .grant    (grant_s)
   );

   // Next-state and next-output logic; memory strobes are computed one cycle
   // ahead so they leave the block straight from flops.
   always_comb begin
      state_s     = state_r;
      gnt_s       = gnt_r;
      last_gnt_s  = last_gnt_r;
      we_s        = we_r;
      last_s      = last_r;
      n_s         = n_r;
      lane_s      = 2'd0;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      rd_buf_s    = rd_buf_r;
      cpu_rdata_s = cpu_rdata_r;
      cpu_done_s  = 1'b0;
      axi_done_s  = 1'b0;
      mem_en_s    = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;

      case (state_r)
         ST_IDLE: begin
            if (grant_s != 2'b00) begin
               state_s  = ST_XFER;
               n_s      = 2'd0;
               rd_buf_s = '0;   // keeps unused upper lanes zero for short loads
               if (grant_s[0]) begin
                  gnt_s   = GNT_CPU;
                  we_s    = bus.cpu_we;
                  last_s  = size_last(bus.cpu_size);
                  addr_s  = bus.cpu_addr;
                  wdata_s = bus.cpu_wdata;
               end else begin
                  gnt_s   = GNT_AXI;
                  we_s    = 1'b1;
                  last_s  = size_last(SIZE_WORD);
                  addr_s  = bus.axi_addr;
                  wdata_s = bus.axi_wdata;
               end
               mem_en_s    = 1'b1;
               mem_we_s    = we_s;
               mem_addr_s  = addr_s;
               mem_wdata_s = wdata_s[7:0];
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_XFER: begin
            // The byte issued last cycle is on mem_rdata now.
            if ((we_r == 1'b0) && (n_r != 2'd0)) begin
               lane_s = n_r - 2'd1;
               rd_buf_s[{lane_s, 3'b000} +: 8] = bus.mem_rdata;
            end else begin
               lane_s = 2'd0;
            end
            if (n_r == last_r) begin
               state_s    = ST_FINISH;
               cpu_done_s = (gnt_r == GNT_CPU);
               axi_done_s = (gnt_r == GNT_AXI);
            end else begin
               state_s     = ST_XFER;
               n_s         = n_r + 2'd1;
               mem_en_s    = 1'b1;
               mem_we_s    = we_r;
               mem_addr_s  = addr_r + ADDR_W'(n_s);   // wraps silently
               mem_wdata_s = wdata_r[{n_s, 3'b000} +: 8];
            end
         end
         ST_FINISH: begin
            state_s    = ST_IDLE;
            last_gnt_s = gnt_r;
            // Last load byte arrives here; publish the whole word at once.
            if ((gnt_r == GNT_CPU) && (we_r == 1'b0)) begin
               rd_buf_s[{last_r, 3'b000} +: 8] = bus.mem_rdata;
               cpu_rdata_s = rd_buf_s;
            end else begin
               cpu_rdata_s = cpu_rdata_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         gnt_r       <= GNT_CPU;
         last_gnt_r  <= GNT_AXI;
         we_r        <= 1'b0;
         last_r      <= 2'd0;
         n_r         <= 2'd0;
         addr_r      <= '0;
         wdata_r     <= '0;
         rd_buf_r    <= '0;
         cpu_rdata_r <= '0;
         cpu_done_r  <= 1'b0;
         axi_done_r  <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 8'd0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         gnt_r       <= gnt_s;
         last_gnt_r  <= last_gnt_s;
         we_r        <= we_s;
         last_r      <= last_s;
         n_r         <= n_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         rd_buf_r    <= rd_buf_s;
         cpu_rdata_r <= cpu_rdata_s;
         cpu_done_r  <= cpu_done_s;
         axi_done_r  <= axi_done_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         busy_r      <= busy_s;
      end
   end

   assign bus.cpu_rdata = cpu_rdata_r;
   assign bus.cpu_done  = cpu_done_r;
   assign bus.axi_done  = axi_done_r;
   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.busy      = busy_r;

endmodule
